// File: rtl/ntt_intt_coef_loader.sv
// Coefficient loader in front of the NTT/INTT datapath.
// Unpacks host words into two reduced coefficients and fills poly RAM.
module ntt_intt_coef_loader #(
  parameter int Q       = 3329,
  parameter int COEF_W  = 12,
  parameter int N_WORDS = 128,
  parameter int ADDR_W  = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  abort_i,
  input  logic                  word_valid_i,
  input  logic [31:0]           word_i,
  input  logic                  consume_i,
  output logic                  wr_en_o,
  output logic [ADDR_W-1:0]     wr_addr_o,
  output logic [2*COEF_W-1:0]   wr_data_o,
  output logic                  busy_o,
  output logic                  full_o,
  output logic                  loaded_o,
  output logic [ADDR_W:0]       count_o,
  output logic                  ovf_o,
  input  logic                  ovf_clr_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_e;

  localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W+1)'(N_WORDS);
  localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(N_WORDS - 1);
  localparam logic [COEF_W-1:0] Q_C      = COEF_W'(Q);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [2*COEF_W-1:0] wr_data_q, wr_data_d;
  logic                ovf_q, ovf_d;

  logic [COEF_W-1:0]   coef_even;
  logic [COEF_W-1:0]   coef_odd;
  logic                last_wr;
  logic                unused_word_bits;

  // One conditional subtraction suffices since inputs are below 2*Q.
  function automatic logic [COEF_W-1:0] reduce(input logic [COEF_W-1:0] c);
    return (c >= Q_C) ? c - Q_C : c;
  endfunction

  assign coef_even = reduce(word_i[COEF_W-1:0]);
  assign coef_odd  = reduce(word_i[16+COEF_W-1:16]);
  assign unused_word_bits = ^{word_i[31:28], word_i[15:12]};

  // The write of the top address is the one that completes the polynomial.
  assign last_wr = wr_en_q && (wr_addr_q == ADDR_TOP);

  // Next state, accept decision, write pipeline and overflow flag.
  always_comb begin
    logic ovf_set;
    state_d   = state_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ovf_set   = 1'b0;

    if (abort_i) begin
      state_d = IDLE;
      count_d = '0;
    end else if (load_i) begin
      state_d = LOAD;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ovf_set = word_valid_i;
        end
        LOAD: begin
          if (last_wr) state_d = FULL;
          if (word_valid_i) begin
            if (count_q < CNT_MAX) begin
              wr_en_d   = 1'b1;
              wr_addr_d = count_q[ADDR_W-1:0];
              wr_data_d = {coef_odd, coef_even};
              count_d   = count_q + (ADDR_W+1)'(1);
            end else begin
              ovf_set = 1'b1;
            end
          end
        end
        FULL: begin
          if (consume_i) state_d = IDLE;
          else           ovf_set = word_valid_i;
        end
        default: state_d = IDLE;
      endcase
    end

    if (ovf_set)        ovf_d = 1'b1;
    else if (ovf_clr_i) ovf_d = 1'b0;
    else                ovf_d = ovf_q;
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ovf_q     <= ovf_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = (state_q == LOAD);
  assign full_o    = (state_q == FULL);
  assign loaded_o  = last_wr;
  assign count_o   = count_q;
  assign ovf_o     = ovf_q;

endmodule
